// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor D = A - B - Bin, one full-subtractor cell, LSB first.
// Latency: WIDTH cycles from input handshake to out_valid; one operation in flight at a time.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready (optional SERIAL_SUB_SATURATE_EN).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
`ifdef SERIAL_SUB_SATURATE_EN
    output logic             sat,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] d_sr;      // difference bits produced so far, MSB-aligned
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] d_final;
    logic [WIDTH-1:0] d_load;

    // Full-subtractor cell on the current LSBs plus the assembled final result.
    always_comb begin
        a_bit   = a_sr[0];
        b_bit   = b_sr[0];
        d_bit   = a_bit ^ b_bit ^ br;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
        d_final = {d_bit, d_sr};
`ifdef SERIAL_SUB_SATURATE_EN
        // Saturate at the load so D reads 0 for the whole DONE phase and after.
        d_load  = br_next ? '0 : d_final;
`else
        d_load  = d_final;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, serial shifting and result register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr <= A;
                        b_sr <= B;
                        br   <= Bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    d_sr <= d_final[WIDTH-1:1];
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        d_q    <= d_load;
                        bout_q <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign D    = d_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_SATURATE_EN
    assign sat  = out_valid & bout_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4 and WIDTH=8.
// Each operation checks latency, result, borrow and return to IDLE.
// Backpressure, reset mid-operation and exhaustive WIDTH=4 vectors included.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, out_valid, out_ready, Bin, Bout, busy;
    logic [3:0] A, B, D;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, Bin8, Bout8, busy8;
    logic [7:0] A8, B8, D8;

`ifdef SERIAL_SUB_SATURATE_EN
    logic       sat, sat8;
`endif

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .Bout(Bout),
`ifdef SERIAL_SUB_SATURATE_EN
        .sat(sat),
`endif
        .busy(busy)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .Bin(Bin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .D(D8), .Bout(Bout8),
`ifdef SERIAL_SUB_SATURATE_EN
        .sat(sat8),
`endif
        .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=4 operation; called just after an edge with the DUT in IDLE.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bin, input string tag);
        logic [4:0] exp;
        logic [3:0] exp_d;
        int         lat;
        exp   = 5'(int'(a) - int'(b) - int'(bin));
        exp_d = exp[3:0];
`ifdef SERIAL_SUB_SATURATE_EN
        if (exp[4]) exp_d = 4'd0;
`endif
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; A = 4'hx; B = 4'hx; Bin = 1'bx;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " result"}, 32'({Bout, D}), 32'({exp[4], exp_d}));
`ifdef SERIAL_SUB_SATURATE_EN
        check({tag, " sat"}, 32'(sat), 32'(exp[4]));
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " idle"}, 32'({out_valid, in_ready, busy}), 32'b010);
        check({tag, " hold"}, 32'({Bout, D}), 32'({exp[4], exp_d}));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; A8 = '0; B8 = '0; Bin8 = 1'b0;
        tick();
        tick();
        check("reset state", 32'({in_ready, out_valid, busy, Bout, D}), 32'b1000_0000);
        rst = 1'b0;
        tick();

        // Basic and wrap-around cases.
        do_op(4'd9, 4'd3, 1'b0, "basic 9-3");
        do_op(4'd0, 4'd1, 1'b0, "wrap 0-1");
        do_op(4'd5, 4'd5, 1'b1, "eq bin1");
        do_op(4'd5, 4'd5, 1'b0, "eq bin0");

        // Backpressure: result held, new operands ignored while not in IDLE.
        A = 4'd12; B = 4'd4; Bin = 1'b0; in_valid = 1'b1;
        tick();
        A = 4'd1; B = 4'd1;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            check("bp hold", 32'({out_valid, in_ready, Bout, D}), 32'({1'b1, 1'b0, 1'b0, 4'd8}));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release", 32'({out_valid, in_ready}), 32'b01);
        repeat (6) tick();
        check("bp single", 32'({out_valid, busy, in_ready}), 32'b001);

        // Reset two cycles into RUN discards the operation.
        A = 4'd15; B = 4'd1; Bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid reset", 32'({in_ready, out_valid, busy, Bout, D}), 32'b1000_0000);
        repeat (5) tick();
        check("mid reset quiet", 32'(out_valid), 32'd0);
        do_op(4'd7, 4'd2, 1'b0, "after reset");

        // Exhaustive WIDTH=4.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    do_op(4'(a), 4'(b), 1'(c), $sformatf("exh %0d-%0d-%0d", a, b, c));

        // WIDTH=8: 0x80 - 0x01 - 1 = 0x7E, latency 8.
        begin
            int lat;
            check("w8 in_ready", 32'(in_ready8), 32'd1);
            A8 = 8'h80; B8 = 8'h01; Bin8 = 1'b1; in_valid8 = 1'b1;
            tick();
            in_valid8 = 1'b0;
            lat = 0;
            while (!out_valid8 && lat < 40) begin
                tick();
                lat++;
            end
            check("w8 latency", 32'(lat), 32'd8);
            check("w8 result", 32'({Bout8, D8}), 32'h07E);
            out_ready8 = 1'b1;
            tick();
            out_ready8 = 1'b0;
            check("w8 idle", 32'({out_valid8, in_ready8}), 32'b01);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle unsigned subtractor: computes D = A - B - Bin, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- The datapath counterpart to the ripple-carry adder: same operand and result layout, with borrow replacing carry.
- Used where area matters more than latency.
- Operands are accepted and results delivered over valid/ready handshakes.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- D  output  WIDTH  difference.
- Bout  output  1  borrow-out; 1 when A < B + Bin (unsigned).
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-RUN):
  - state goes to IDLE; bit counter cleared; borrow register cleared; shift registers cleared.
  - outputs: in_ready=1, out_valid=0, D=0, Bout=0, busy=0.
  - any operation in flight is discarded; no result is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: latch A and B into shift registers, load the borrow register with Bin, clear the counter, go to RUN.
  - Operand values outside the accepting edge are ignored.
- RUN (lasts exactly WIDTH cycles):
  - Each cycle, on bits a (A shift reg LSB), b (B shift reg LSB) and borrow register br:
    - d = a^b^br
    - br_next = (~a & b) | (~(a^b) & br)
  - d is shifted into D's shift register from the MSB side; A and B shift right.
  - Counter increments. When counter == WIDTH-1 at an edge, go to DONE, with D complete and Bout = final br_next.
- DONE:
  - out_valid=1; D and Bout stable.
  - On out_valid & out_ready at an edge: go to IDLE, out_valid=0.
  - D and Bout hold their last values after acceptance, until the next operation's final RUN edge.
- Latency: in-handshake edge to out_valid high = WIDTH cycles.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH RUN cycles, one DONE cycle with out_ready=1).
- No back-to-back overlap: in_ready stays 0 from the accepting edge until the edge that completes the output handshake.
- in_valid during RUN or DONE is ignored; the upstream must hold it.
- out_ready while not in DONE has no effect.
- Arithmetic is modulo 2^WIDTH:
  - wrap-around, e.g. 0 - 1 gives D = all ones, Bout=1.
  - A = B with Bin=1 gives all ones, Bout=1.
  - A = B with Bin=0 gives 0, Bout=0.
- Counter width is clog2(WIDTH); no dependency on other modules.

Optional Feature:
- Macro SERIAL_SUB_SATURATE_EN.
- When defined: in DONE, if Bout=1 then D is forced to 0 (unsigned saturating subtract). Bout still reports the borrow. Added output port sat, 1 bit, equal to Bout while out_valid=1, 0 otherwise and at reset.
- When undefined: D is the raw modulo result; no sat port; saturation logic absent.

Test Plan:
- Basic subtract, WIDTH=4: A=9, B=3, Bin=0 accepted at edge t -> out_valid at t+4, D=6, Bout=0; out_ready=1 -> IDLE next edge, in_ready=1.
- Wrap-around: A=0, B=1, Bin=0 -> D=15, Bout=1. A=5, B=5, Bin=1 -> D=15, Bout=1 (with SERIAL_SUB_SATURATE_EN: D=0, sat=1).
- Backpressure: A=12, B=4, out_ready held 0 for 5 cycles -> out_valid, D=8, Bout=0 stable throughout; in_ready=0; new in_valid ignored; release -> single acceptance.
- Reset mid-operation: assert rst two cycles into RUN of A=15, B=1 -> next edge state IDLE, out_valid=0, D=0, Bout=0, in_ready=1; a subsequent A=7, B=2 yields D=5.
- Exhaustive WIDTH=4: all A, B in 0..15, Bin in 0..1 -> {Bout, D} equals the 5-bit two's-complement value of A-B-Bin; latency exactly 4 every time.
- WIDTH=8: A=0x80, B=0x01, Bin=1 -> D=0x7E, Bout=0, latency 8.
